// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit control blocks:
// FSM state encoding, default baud divisor, frame shape constants and a
// small edge-detect helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // FSM state encoding, common to the RX and TX control paths
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } uart_state_e;

  // 50 MHz system clock / 115200 baud
  localparam int DEFAULT_BPS_DIV = 434;

  // 8N1 frame shape
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // High-to-low transition between the previous and the current line value
  function automatic logic is_fall(input logic prev_val, input logic cur_val);
    return prev_val & ~cur_val;
  endfunction

endpackage : uart_pkg

// File: rtl/rx_bps_module.sv
// -----------------------------------------------------------------------------
// rx_bps_module
// Baud counter for the UART receiver. Counts 0..BPS_DIV-1 while enabled and
// is held at 0 while disabled, so every frame starts with a clean phase.
//
// Ports:
//   CLK         in   system clock, rising edge
//   Rstn        in   asynchronous active-low reset
//   Count_En    in   1 = count, 0 = hold counter at 0
//   Sample_Sig  out  counter == HALF (bit centre)
//   Bit_End_Sig out  counter == BPS_DIV-1 (last cycle of a bit period)
// -----------------------------------------------------------------------------
module rx_bps_module
  import uart_pkg::*;
#(
  parameter int BPS_DIV = DEFAULT_BPS_DIV
) (
  input  logic CLK,
  input  logic Rstn,
  input  logic Count_En,
  output logic Sample_Sig,
  output logic Bit_End_Sig
);

  localparam int HALF  = BPS_DIV / 2;
  localparam int CNT_W = $clog2(BPS_DIV);

  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BPS_DIV - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Free-running bit-period counter, cleared whenever counting is disabled
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_count <= '0;
    end else if (!Count_En) begin
      r_count <= '0;
    end else if (r_count == LAST_C) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE_C;
    end
  end

  assign Sample_Sig  = (r_count == HALF_C);
  assign Bit_End_Sig = (r_count == LAST_C);

endmodule : rx_bps_module

// File: rtl/uart_rx_control_module.sv
// -----------------------------------------------------------------------------
// uart_rx_control_module
// Receives 8N1 bytes (LSB first) from an asynchronous serial line. The line is
// synchronised, a start-bit falling edge launches the frame, every bit is
// sampled at its centre, and the stop bit decides between a done strobe (with
// RX_Data updated) and an error strobe (RX_Data untouched).
//
// Ports:
//   CLK          in   system clock, rising edge
//   Rstn         in   asynchronous active-low reset
//   RX_Pin_In    in   serial line, asynchronous, idle high
//   RX_En_Sig    in   receive enable; low aborts any frame in progress
//   RX_Data      out  last correctly framed byte
//   RX_Done_Sig  out  one-cycle pulse, RX_Data updated in the same cycle
//   RX_Err_Sig   out  one-cycle pulse on a framing error (stop bit 0)
// -----------------------------------------------------------------------------
module uart_rx_control_module
  import uart_pkg::*;
#(
  parameter int BPS_DIV = DEFAULT_BPS_DIV
) (
  input  logic                 CLK,
  input  logic                 Rstn,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 RX_Err_Sig
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_ONE  = BIT_IDX_W'(1);

  // Line synchroniser and edge history
  logic r_sync1;
  logic r_sync2;
  logic r_hist;
  logic w_fall;

  // FSM
  uart_state_e r_state;
  uart_state_e w_state_nxt;

  // Baud strobes
  logic w_count_en;
  logic w_sample;
  logic w_unused_bit_end;

  // Datapath
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_shift_we;
  logic                 w_done_nxt;
  logic                 w_err_nxt;

  // The counter runs in every state except IDLE, so entering START always
  // finds it at 0 and the first sample lands HALF cycles after the edge.
  assign w_count_en = (r_state != S_IDLE);

  rx_bps_module #(
    .BPS_DIV (BPS_DIV)
  ) u_rx_bps (
    .CLK         (CLK),
    .Rstn        (Rstn),
    .Count_En    (w_count_en),
    .Sample_Sig  (w_sample),
    .Bit_End_Sig (w_unused_bit_end)
  );

  // Two-stage synchroniser plus history; history updates in every state so an
  // edge right after a mid-stop-bit return to IDLE is still seen.
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= RX_Pin_In;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_fall = is_fall(r_hist, r_sync2);

  // FSM state register
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; dropping the enable aborts from any active state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall && RX_En_Sig) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (!RX_En_Sig) begin
          w_state_nxt = S_IDLE;
        end else if (w_sample) begin
          // Line back high at the start-bit centre: glitch, not a frame
          w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (!RX_En_Sig) begin
          w_state_nxt = S_IDLE;
        end else if (w_sample && (r_bit_idx == LAST_IDX)) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        // Leave at the stop-bit centre so a zero-gap next start is caught
        if (!RX_En_Sig) begin
          w_state_nxt = S_IDLE;
        end else if (w_sample) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output decode: shift strobe and next values of the result pulses
  always_comb begin
    w_shift_we = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (RX_En_Sig && w_sample) begin
      case (r_state)
        S_DATA: begin
          w_shift_we = 1'b1;
        end
        S_STOP: begin
          if (r_sync2) begin
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: begin
          w_shift_we = 1'b0;
        end
      endcase
    end else begin
      w_shift_we = 1'b0;
    end
  end

  // Bit index and shift register; index parks at 0 whenever the FSM is idle
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (r_state == S_IDLE) begin
      r_bit_idx <= '0;
    end else if (w_shift_we) begin
      r_shift[r_bit_idx] <= r_sync2;
      r_bit_idx          <= r_bit_idx + IDX_ONE;
    end else begin
      r_bit_idx <= r_bit_idx;
    end
  end

  // Registered outputs; RX_Data only changes together with a done pulse
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      RX_Data     <= '0;
      RX_Done_Sig <= 1'b0;
      RX_Err_Sig  <= 1'b0;
    end else begin
      RX_Done_Sig <= w_done_nxt;
      RX_Err_Sig  <= w_err_nxt;
      if (w_done_nxt) begin
        RX_Data <= r_shift;
      end else begin
        RX_Data <= RX_Data;
      end
    end
  end

endmodule : uart_rx_control_module

// File: tb/tb_uart_rx_control_module.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_control_module
// Directed bench for uart_rx_control_module at BPS_DIV = 16 (HALF = 8).
// A table of single frames is applied in a loop; back-to-back frames, a false
// start, an enable abort and a mid-frame reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx_control_module;
  import uart_pkg::*;

  localparam int BPS = 16;
  // Cycles from driving the start-bit low to the result pulse being visible:
  // 3 edges to T0, stop sample at T0 + 9*BPS + BPS/2, pulse one edge later.
  localparam int LAT = 3 + 9 * BPS + BPS / 2 + 1;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pin;
  logic       en;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = 0;
  int both_cnt = 0;
  int chg_cnt  = 0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_rstn = 1'b0;

  typedef struct {
    int         t;
    logic       is_err;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;
  vec_t vecs[6];

  uart_rx_control_module #(
    .BPS_DIV (BPS)
  ) dut (
    .CLK         (clk),
    .Rstn        (rstn),
    .RX_Pin_In   (pin),
    .RX_En_Sig   (en),
    .RX_Data     (rx_data),
    .RX_Done_Sig (rx_done),
    .RX_Err_Sig  (rx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rx_done && rx_err) both_cnt <= both_cnt + 1;
    if (rx_done || rx_err) evq.push_back('{cyc, rx_err, rx_data});
    if (rstn && prev_rstn && !rx_done && (rx_data !== prev_data)) chg_cnt <= chg_cnt + 1;
    prev_data <= rx_data;
    prev_rstn <= rstn;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop);
    pin = 1'b0;
    last_fall = cyc;
    tick(BPS);
    for (int i = 0; i < 8; i++) begin
      pin = d[i];
      tick(BPS);
    end
    pin = stop;
    tick(BPS);
  endtask

  task automatic chk_one(input string name, input logic [7:0] exp_d, input logic exp_err);
    chk({name, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      chk({name, "_time"}, evq[0].t, last_fall + LAT);
      chk({name, "_kind"}, evq[0].is_err, exp_err);
      chk({name, "_data"}, evq[0].d, exp_d);
    end
  endtask

  initial begin : main
    logic [7:0] d5;
    logic [7:0] d6;
    int f1;
    int f2;
    int ff;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b0};

    rstn = 1'b0;
    pin  = 1'b1;
    en   = 1'b1;
    tick(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_err",  rx_err,  1'b0);
    rstn = 1'b1;
    tick(5);

    // Single frames with one idle bit after the stop bit
    for (int i = 0; i < 6; i++) begin
      evq.delete();
      send_bits(vecs[i].d, vecs[i].stop);
      pin = 1'b1;
      tick(BPS);
      chk_one($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err);
      chk($sformatf("vec%0d_hold", i), rx_data, vecs[i].exp_data);
    end

    // Back-to-back frames, zero idle gap
    evq.delete();
    send_bits(8'h00, 1'b1);
    f1 = last_fall;
    send_bits(8'hFF, 1'b1);
    f2 = last_fall;
    pin = 1'b1;
    tick(BPS);
    chk("b2b_count", evq.size(), 2);
    if (evq.size() > 1) begin
      chk("b2b_t0",   evq[0].t, f1 + LAT);
      chk("b2b_t1",   evq[1].t, f2 + LAT);
      chk("b2b_gap",  evq[1].t - evq[0].t, 160);
      chk("b2b_d0",   evq[0].d, 8'h00);
      chk("b2b_d1",   evq[1].d, 8'hFF);
      chk("b2b_k0",   evq[0].is_err, 1'b0);
      chk("b2b_k1",   evq[1].is_err, 1'b0);
    end

    // False start: line low 3 cycles
    evq.delete();
    pin = 1'b0;
    ff = cyc;
    tick(3);
    pin = 1'b1;
    tick(5);
    chk("false_in_start", dut.r_state, S_START);
    tick(ff + 13 - cyc);
    chk("false_idle", dut.r_state, S_IDLE);
    tick(200);
    chk("false_none", evq.size(), 0);
    chk("false_hold", rx_data, 8'hFF);
    send_bits(8'h96, 1'b1);
    pin = 1'b1;
    tick(BPS);
    chk_one("after_false", 8'h96, 1'b0);

    // Enable dropped during data bit 4 of 0x5A, then 0x81 with enable high
    evq.delete();
    d5 = 8'h5A;
    pin = 1'b0;
    tick(BPS);
    for (int i = 0; i < 4; i++) begin
      pin = d5[i];
      tick(BPS);
    end
    pin = d5[4];
    tick(BPS / 2);
    en = 1'b0;
    tick(2);
    chk("en_drop_idle", dut.r_state, S_IDLE);
    tick(BPS / 2 - 2);
    for (int i = 5; i < 8; i++) begin
      pin = d5[i];
      tick(BPS);
    end
    pin = 1'b1;
    tick(2 * BPS);
    en = 1'b1;
    tick(2);
    chk("en_drop_none", evq.size(), 0);
    chk("en_drop_hold", rx_data, 8'h96);
    send_bits(8'h81, 1'b1);
    pin = 1'b1;
    tick(BPS);
    chk_one("en_next", 8'h81, 1'b0);

    // Reset during data bit 6 of 0xF0, then 0x12
    evq.delete();
    d6 = 8'hF0;
    pin = 1'b0;
    tick(BPS);
    for (int i = 0; i < 6; i++) begin
      pin = d6[i];
      tick(BPS);
    end
    pin = d6[6];
    tick(BPS / 2);
    rstn = 1'b0;
    #1;
    chk("midrst_data",  rx_data, 8'h00);
    chk("midrst_done",  rx_done, 1'b0);
    chk("midrst_err",   rx_err,  1'b0);
    chk("midrst_state", dut.r_state, S_IDLE);
    tick(BPS / 2);
    pin = d6[7];
    tick(BPS);
    pin = 1'b1;
    tick(BPS);
    rstn = 1'b1;
    tick(BPS);
    chk("midrst_none", evq.size(), 0);
    chk("midrst_hold", rx_data, 8'h00);
    send_bits(8'h12, 1'b1);
    pin = 1'b1;
    tick(BPS);
    chk_one("midrst_next", 8'h12, 1'b0);

    chk("never_both",  both_cnt, 0);
    chk("data_stable", chg_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_control_module
